// File: rtl/counter_prog_limit_ovf.sv
// Programmable-limit up/down counter with wrap/saturate, sync load, fixed prescaler,
// and registered wrap pulse plus sticky overflow flag.
module counter_prog_limit_ovf #(
    parameter int N        = 3,
    parameter int LIMIT    = 4,
    parameter int PRESCALE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic         clear,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         dir,
    input  logic         sat,
    input  logic         limit_we,
    input  logic [N-1:0] limit_in,
    input  logic         sticky_clr,
    output logic [N-1:0] Q,
    output logic [N-1:0] limit_q,
    output logic         overflow,
    output logic         pre_overflow,
    output logic         wrap_pulse,
    output logic         sticky_ovf
);

    // A one-bit prescaler is kept even for PRESCALE=1; it simply never leaves 0.
    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [N-1:0]  q_q, q_d;
    logic [N-1:0]  lim_q, lim_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          wrap_q, wrap_d;
    logic          sticky_q, sticky_d;
    logic          step;
    logic          wrap_ev;

    assign step = enable && (pre_q == PRE_LAST);

    always_comb begin
        pre_d = pre_q;
        if (clear || load) begin
            pre_d = '0;
        end else if (enable) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
        end
    end

    // Step compares against the current lim_q, so a limit write on the same edge
    // only affects later steps.
    always_comb begin
        q_d     = q_q;
        wrap_ev = 1'b0;
        if (clear) begin
            q_d = '0;
        end else if (load) begin
            q_d = load_val;
        end else if (step) begin
            if (!dir) begin
                if (q_q >= lim_q) begin
                    if (!sat) begin
                        q_d     = '0;
                        wrap_ev = 1'b1;
                    end
                end else begin
                    q_d = q_q + N'(1);
                end
            end else begin
                if (q_q == '0) begin
                    if (!sat) begin
                        q_d     = lim_q;
                        wrap_ev = 1'b1;
                    end
                end else begin
                    q_d = q_q - N'(1);
                end
            end
        end
    end

    always_comb begin
        lim_d    = limit_we ? limit_in : lim_q;
        wrap_d   = wrap_ev;
        sticky_d = (sticky_q && !sticky_clr) || wrap_ev;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q      <= '0;
            pre_q    <= '0;
            lim_q    <= N'(LIMIT);
            wrap_q   <= 1'b0;
            sticky_q <= 1'b0;
        end else begin
            q_q      <= q_d;
            pre_q    <= pre_d;
            lim_q    <= lim_d;
            wrap_q   <= wrap_d;
            sticky_q <= sticky_d;
        end
    end

    assign Q          = q_q;
    assign limit_q    = lim_q;
    assign wrap_pulse = wrap_q;
    assign sticky_ovf = sticky_q;

    // Exact compares: an up-counter parked above the limit reports neither flag.
    always_comb begin
        if (dir) begin
            overflow     = (q_q == '0);
            pre_overflow = (q_q == N'(1));
        end else begin
            overflow     = (q_q == lim_q);
            pre_overflow = (lim_q != '0) && (q_q == lim_q - N'(1));
        end
    end

endmodule

// File: tb/tb_counter_prog_limit_ovf.sv
// Directed bench for counter_prog_limit_ovf: a PRESCALE=1 and a PRESCALE=3 instance
// share stimulus; each phase checks only the instance it targets.
module tb_counter_prog_limit_ovf;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable, clear, load, dir, sat, limit_we, sticky_clr;
    logic [2:0] load_val, limit_in;

    logic [2:0] q1, lim1, q3, lim3;
    logic       ovf1, pre1, wrp1, stk1;
    logic       ovf3, pre3, wrp3, stk3;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    counter_prog_limit_ovf #(.N(3), .LIMIT(4), .PRESCALE(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .load(load),
        .load_val(load_val), .dir(dir), .sat(sat), .limit_we(limit_we),
        .limit_in(limit_in), .sticky_clr(sticky_clr), .Q(q1), .limit_q(lim1),
        .overflow(ovf1), .pre_overflow(pre1), .wrap_pulse(wrp1), .sticky_ovf(stk1)
    );

    counter_prog_limit_ovf #(.N(3), .LIMIT(4), .PRESCALE(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .clear(clear), .load(load),
        .load_val(load_val), .dir(dir), .sat(sat), .limit_we(limit_we),
        .limit_in(limit_in), .sticky_clr(sticky_clr), .Q(q3), .limit_q(lim3),
        .overflow(ovf3), .pre_overflow(pre3), .wrap_pulse(wrp3), .sticky_ovf(stk3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Phase 1 vectors: Q, wrap_pulse, sticky_clr driven, sticky_ovf after each edge
    int p1_q  [11] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1};
    int p1_w  [11] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0};
    int p1_sc [11] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    int p1_st [11] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 0};

    // Phase 3 vectors for the PRESCALE=3 instance: enable, clear, expected Q
    int p3_en [16] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    int p3_cl [16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    int p3_q  [16] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3, 3, 0, 0, 0, 1};

    initial begin
        rst_n = 1'b0;
        enable = 0; clear = 0; load = 0; dir = 0; sat = 0;
        limit_we = 0; sticky_clr = 0; load_val = '0; limit_in = '0;
        #12;
        chk("rst_q", q1, 0);
        chk("rst_limit", lim1, 4);
        chk("rst_wrap", wrp1, 0);
        chk("rst_sticky", stk1, 0);
        chk("rst_ovf", ovf1, 0);
        chk("rst_pre", pre1, 0);
        rst_n = 1'b1;

        // Phase 1: up, wrap, limit 4
        enable = 1;
        for (int i = 0; i < 11; i++) begin
            sticky_clr = p1_sc[i][0];
            tick();
            chk($sformatf("p1_q[%0d]", i), q1, p1_q[i]);
            chk($sformatf("p1_wrap[%0d]", i), wrp1, p1_w[i]);
            chk($sformatf("p1_sticky[%0d]", i), stk1, p1_st[i]);
            chk($sformatf("p1_ovf[%0d]", i), ovf1, (p1_q[i] == 4) ? 1 : 0);
            chk($sformatf("p1_pre[%0d]", i), pre1, (p1_q[i] == 3) ? 1 : 0);
        end
        sticky_clr = 0;

        // Phase 2: down, saturate, then wrap
        dir = 1; sat = 1; enable = 0; load = 1; load_val = 3'd2;
        tick();
        chk("p2_load", q1, 2);
        load = 0; enable = 1;
        tick(); chk("p2_q1", q1, 1); chk("p2_pre1", pre1, 1); chk("p2_ovf1", ovf1, 0);
        tick(); chk("p2_q0", q1, 0); chk("p2_ovf0", ovf1, 1); chk("p2_w0", wrp1, 0);
        tick(); chk("p2_hold_a", q1, 0); chk("p2_w1", wrp1, 0); chk("p2_ovf_a", ovf1, 1);
        tick(); chk("p2_hold_b", q1, 0); chk("p2_w2", wrp1, 0); chk("p2_ovf_b", ovf1, 1);
        sat = 0;
        tick(); chk("p2_wrap_q", q1, 4); chk("p2_wrap_p", wrp1, 1); chk("p2_wrap_ovf", ovf1, 0);
        tick(); chk("p2_after_q", q1, 3); chk("p2_after_p", wrp1, 0);

        // Phase 3: PRESCALE=3 instance
        dir = 0; sat = 0; enable = 0; clear = 1;
        tick();
        chk("p3_clr", q3, 0);
        clear = 0;
        for (int i = 0; i < 16; i++) begin
            enable = p3_en[i][0];
            clear  = p3_cl[i][0];
            tick();
            chk($sformatf("p3_q[%0d]", i), q3, p3_q[i]);
        end
        clear = 0; enable = 0;

        // Phase 4: runtime limit changes on the PRESCALE=1 instance
        limit_we = 1; limit_in = 3'd6;
        tick();
        chk("p4_lim6", lim1, 6);
        limit_we = 0; load = 1; load_val = 3'd5;
        tick();
        chk("p4_q5", q1, 5); chk("p4_ovf5", ovf1, 0); chk("p4_pre5", pre1, 1);
        load = 0; limit_we = 1; limit_in = 3'd3;
        tick();
        chk("p4_lim3", lim1, 3); chk("p4_q5b", q1, 5);
        chk("p4_ovf_above", ovf1, 0); chk("p4_pre_above", pre1, 0);
        limit_we = 0; enable = 1;
        tick();
        chk("p4_wrap_q", q1, 0); chk("p4_wrap_p", wrp1, 1);
        enable = 0; load = 1; load_val = 3'd7;
        tick();
        chk("p4_q7", q1, 7); chk("p4_q7_w", wrp1, 0); chk("p4_q7_ovf", ovf1, 0);
        load = 0; enable = 1;
        tick();
        chk("p4_q7_wrap", q1, 0); chk("p4_q7_wp", wrp1, 1);

        // Phase 5: priority
        enable = 0; load = 1; load_val = 3'd3;
        tick();
        chk("p5_term", ovf1, 1);
        clear = 1; load = 1; load_val = 3'd5; enable = 1;
        tick();
        chk("p5_clr_q", q1, 0); chk("p5_clr_w", wrp1, 0);
        clear = 0; load = 1; load_val = 3'd3; enable = 0;
        tick();
        load_val = 3'd2; enable = 1;
        tick();
        chk("p5_ld_q", q1, 2); chk("p5_ld_w", wrp1, 0);
        load_val = 3'd3; enable = 0;
        tick();
        load = 0; enable = 1; limit_we = 1; limit_in = 3'd6;
        tick();
        chk("p5_oldlim_q", q1, 0); chk("p5_oldlim_w", wrp1, 1); chk("p5_oldlim_l", lim1, 6);
        enable = 0; limit_in = 3'd0;
        tick();
        chk("p5_lim0_ovf", ovf1, 1); chk("p5_lim0_pre", pre1, 0); chk("p5_lim0_w", wrp1, 0);

        // Phase 6: async reset mid-count
        limit_in = 3'd6; load = 1; load_val = 3'd2;
        tick();
        limit_we = 0; load = 0; enable = 1;
        tick();
        chk("p6_pre_q", q1, 3); chk("p6_pre_stk", stk1, 1); chk("p6_pre_lim", lim1, 6);
        chk("p6_pre_q3", q3, 2);
        enable = 0;
        #2 rst_n = 1'b0;
        #1;
        chk("p6_rst_q", q1, 0); chk("p6_rst_lim", lim1, 4); chk("p6_rst_stk", stk1, 0);
        chk("p6_rst_w", wrp1, 0); chk("p6_rst_ovf", ovf1, 0); chk("p6_rst_q3", q3, 0);
        enable = 1;
        #2 rst_n = 1'b1;
        tick(); chk("p6_run_q1", q1, 1); chk("p6_run_q3a", q3, 0);
        tick(); chk("p6_run_q3b", q3, 0);
        tick(); chk("p6_run_q3c", q3, 1); chk("p6_run_q1c", q1, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/counter_prog_limit_ovf.md
# counter_prog_limit_ovf

Runtime-programmable limit counter with up/down counting, wrap or saturate at the terminal value, synchronous load, a fixed prescaler, and registered and sticky overflow reporting. It is the parametrised successor of the fixed-limit overflow counter. Datapath and control logic use it for multicycle sequencing, timeouts and baud/tick generation where the limit must change without re-synthesis.

## Interface
Parameters:
- N, 3, counter width in bits.
- LIMIT, 4, reset value of the limit register; must be < 2^N.
- PRESCALE, 1, enabled cycles per count step; must be ≥ 1. A value of 1 means every enabled cycle steps.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  count enable; also advances the prescaler.
- clear  in  1  synchronous clear of Q and the prescaler.
- load  in  1  synchronous load of load_val into Q; also clears the prescaler.
- load_val  in  N  value loaded into Q.
- dir  in  1  count direction: 0 = up, 1 = down.
- sat  in  1  terminal behaviour: 0 = wrap, 1 = saturate (hold).
- limit_we  in  1  write enable for the limit register.
- limit_in  in  N  new limit value.
- sticky_clr  in  1  clears sticky_ovf.
- Q  out  N  counter value (registered).
- limit_q  out  N  current limit (registered).
- overflow  out  1  combinational; Q is at the terminal value.
- pre_overflow  out  1  combinational; Q is one step before the terminal value.
- wrap_pulse  out  1  registered; one-cycle pulse when a wrap occurs.
- sticky_ovf  out  1  registered; set on wrap, held until sticky_clr.

## Operation
- Reset (rst_n=0, asynchronous):
  - Q=0, prescaler=0, limit_q=LIMIT, wrap_pulse=0, sticky_ovf=0.
  - Asserting rst_n mid-count aborts immediately. No pending step survives reset.
- Step tick: step = enable && prescaler==PRESCALE-1.
  - When enable=1, the prescaler increments and wraps to 0 when it reaches PRESCALE-1.
  - When enable=0, the prescaler holds.
- Terminal value: T = limit_q when dir=0; T = 0 when dir=1.
- Q update priority, highest first: clear > load > step > hold.
  - clear: Q←0, prescaler←0.
  - load: Q←load_val, prescaler←0. load_val > limit_q is accepted as-is.
  - step, up, Q ≥ limit_q: Q←0 (wrap) if sat=0; Q holds if sat=1. Q ≥ limit_q covers Q loaded above the limit or the limit lowered below Q.
  - step, up, otherwise: Q←Q+1.
  - step, down, Q==0: Q←limit_q (wrap) if sat=0; Q holds at 0 if sat=1.
  - step, down, otherwise: Q←Q-1. This applies even when Q > limit_q.
- Wrap event: a step that takes one of the two wrap branches. Saturated holds, clear and load are not wraps.
- wrap_pulse ← wrap event, on every edge.
- sticky_ovf ← (sticky_ovf && !sticky_clr) || wrap event. A set on the same edge as sticky_clr wins.
- limit_q ← limit_in on an edge with limit_we=1. This is independent of clear, load and step.
  - The step on that same edge compares against the old limit_q.
- overflow = (Q == T). For dir=0 this means Q == limit_q exactly, so it is 0 while Q > limit_q.
- pre_overflow:
  - dir=0: limit_q ≠ 0 && Q == limit_q-1.
  - dir=1: Q == 1.
  - Both are N-bit compares with no wrap-around; with limit_q=0 in up mode, pre_overflow stays 0.
- Changing dir or sat takes effect on the next step; no state is reset.

## Timing
- Count latency: a step sampled at edge k updates Q at edge k. overflow and pre_overflow follow Q combinationally in the same cycle.
- With PRESCALE=P and enable held high from a cleared state, Q advances on every P-th edge: the first step is on edge P.
- wrap_pulse is high for exactly one cycle after the wrapping edge, aligned with Q=0 (up) or Q=limit_q (down).
  - With PRESCALE=1 and limit_q=L, back-to-back up wraps give one pulse every L+1 cycles.
- sticky_ovf rises in the same cycle as wrap_pulse.
- A new limit_q is visible to overflow and pre_overflow in the cycle after limit_we.
- clear or load asserted together with a would-be wrap step suppresses both the wrap and wrap_pulse.

## Test plan
- Defaults (N=3, LIMIT=4, PRESCALE=1), up, wrap, enable=1 from reset:
  - Required Q sequence: 0,1,2,3,4,0,1…
  - pre_overflow high at Q=3; overflow high at Q=4.
  - wrap_pulse high exactly in the cycle Q returns to 0.
  - sticky_ovf set and held until sticky_clr; assert sticky_clr on the same edge as the next wrap → sticky_ovf stays 1.
- Down with sat=1, limit_q=4:
  - load 2, step ×4 → Q: 2,1,0,0,0.
  - overflow=1 from Q=0 onward; wrap_pulse never asserts.
  - Switch sat=0 → next step gives Q=4 and one wrap_pulse.
- PRESCALE=3, up, limit 4:
  - Q increments on edges 3, 6, 9… with enable held.
  - Drop enable for 2 cycles mid-period → prescaler holds and the step is delayed by exactly 2 cycles.
  - clear mid-period → Q=0 and the next step is 3 enabled cycles later.
- Runtime limit, up:
  - At Q=5 with limit_q=6, write limit_in=3 → next step wraps Q to 0 with wrap_pulse. overflow is 0 at Q=5 against the new limit.
  - load_val=7 with limit 3 → next step gives Q=0.
- Priority:
  - clear+load+step on the same edge → Q=0, no wrap_pulse.
  - load(2)+step at a terminal value → Q=2, no wrap_pulse.
  - limit_we on a wrap edge uses the old limit.
- Async reset mid-count (Q=3, prescaler mid-period, sticky set, limit_q=6):
  - Drop rst_n between edges → all outputs return to reset values immediately (limit_q=4).
  - After release, counting restarts from 0.
